branch_predict_resolve: RTL and testbench

//  Successor to the combinational branch-taken check: resolves conditional branches and jumps in EX,

---
 rtl/branch_predict_resolve_pkg.sv | 24 ++
 rtl/branch_predict_resolve_sat_counter_table.sv | 46 ++++
 rtl/branch_predict_resolve.sv | 106 ++++++++++
 tb/tb_branch_predict_resolve.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_resolve_pkg.sv
// Shared definitions for the EX-stage branch resolver and its counter table.
package branch_predict_resolve_pkg;

  typedef enum logic [1:0] {
    COND_EQZ = 2'b00,
    COND_NEZ = 2'b01,
    COND_LTZ = 2'b10,
    COND_GEZ = 2'b11
  } cond_e;

  localparam int unsigned HELPER_W = 64;

  // Weak not-taken: just below the taken threshold.
  function automatic logic [HELPER_W-1:0] ctr_reset_val(input int unsigned ctr_w);
    return (HELPER_W'(1) << (ctr_w - 1)) - HELPER_W'(1);
  endfunction

  // Word-aligned PCs: skip the two byte-offset bits.
  function automatic logic [HELPER_W-1:0] pc_index(input logic [HELPER_W-1:0] pc,
                                                   input int unsigned idx_w);
    return (pc >> 2) & ((HELPER_W'(1) << idx_w) - HELPER_W'(1));
  endfunction

endpackage

// File: rtl/branch_predict_resolve_sat_counter_table.sv
// Direct-mapped table of saturating counters: one combinational read port,
// one increment/decrement write port. Reads never see same-cycle writes.
module sat_counter_table
  import branch_predict_resolve_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_inc
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_reset_val(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic [CTR_W-1:0] ctr_q [ENTRIES];
  logic [CTR_W-1:0] ctr_d [ENTRIES];

  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      if (wr_inc) begin
        if (ctr_q[wr_idx] != CTR_MAX) ctr_d[wr_idx] = ctr_q[wr_idx] + CTR_W'(1);
      end else begin
        if (ctr_q[wr_idx] != '0) ctr_d[wr_idx] = ctr_q[wr_idx] - CTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RST;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// EX-stage branch/jump resolver: checks the IF prediction, issues a one-cycle
// registered flush/redirect on mispredict, trains the predictor, counts misses.
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned CTR_W  = 2,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_jump,
  input  logic [1:0]        ex_cond,
  input  logic [ADDR_W-1:0] ex_operand,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  output logic              leap,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] redirect_q, redirect_d;
  logic [STAT_W-1:0] stat_q, stat_d;

  logic              cond_true;
  logic              live;
  logic              act;
  logic              mis;
  logic              train;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [CTR_W-1:0]  rd_ctr;

  // Condition evaluation against zero.
  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(ex_cond))
      COND_EQZ: cond_true = (ex_operand == '0);
      COND_NEZ: cond_true = (ex_operand != '0);
      COND_LTZ: cond_true = ex_operand[ADDR_W-1];
      COND_GEZ: cond_true = ~ex_operand[ADDR_W-1];
      default:  cond_true = 1'b0;
    endcase
  end

  // While a flush is out, EX holds a wrong-path instruction and is ignored.
  assign live  = ex_valid & ~flush_q;
  assign act   = live & (ex_jump | (ex_branch & cond_true));
  assign mis   = live & (ex_branch | ex_jump) & (act != ex_pred_taken);
  assign train = live & ex_branch & ~ex_jump;
  assign leap  = act;

  assign rd_idx = IDX_W'(pc_index(HELPER_W'(if_pc), IDX_W));
  assign wr_idx = IDX_W'(pc_index(HELPER_W'(ex_pc), IDX_W));
  assign if_pred_taken = rd_ctr[CTR_W-1];

  sat_counter_table #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_table (
    .clk    (clk),
    .reset  (reset),
    .rd_idx (rd_idx),
    .rd_ctr (rd_ctr),
    .wr_en  (train),
    .wr_idx (wr_idx),
    .wr_inc (act)
  );

  always_comb begin
    flush_d    = mis;
    redirect_d = redirect_q;
    stat_d     = stat_q;
    if (mis) begin
      redirect_d = act ? ex_target : ex_pc + ADDR_W'(4);
      if (stat_q != STAT_MAX) stat_d = stat_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
      stat_q     <= '0;
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      stat_q     <= stat_d;
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign mispred_cnt = stat_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed table-driven bench for branch_predict_resolve (STAT_W=2 to reach saturation quickly).
module tb_branch_predict_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_branch, ex_jump, ex_pred_taken;
  logic [1:0]  ex_cond;
  logic [31:0] ex_operand, ex_pc, ex_target;
  logic        leap, flush;
  logic [31:0] redirect_pc;
  logic [1:0]  mispred_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_predict_resolve #(
    .ADDR_W (32),
    .IDX_W  (4),
    .CTR_W  (2),
    .STAT_W (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .ex_valid      (ex_valid),
    .ex_branch     (ex_branch),
    .ex_jump       (ex_jump),
    .ex_cond       (ex_cond),
    .ex_operand    (ex_operand),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .leap          (leap),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .mispred_cnt   (mispred_cnt)
  );

  typedef struct packed {
    logic        v, br, jp;
    logic [1:0]  cond;
    logic [31:0] op, pc, tgt;
    logic        pred;
    logic [31:0] ifpc;
    logic        e_leap, e_ifpt, e_flush;
    logic [31:0] e_redir;
    logic [1:0]  e_cnt;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  function automatic vec_t mk(logic v, logic br, logic jp, logic [1:0] cond, logic [31:0] op,
                              logic [31:0] pc, logic [31:0] tgt, logic pred, logic [31:0] ifpc,
                              logic e_leap, logic e_ifpt, logic e_flush, logic [31:0] e_redir,
                              logic [1:0] e_cnt);
    vec_t r;
    r.v = v; r.br = br; r.jp = jp; r.cond = cond; r.op = op; r.pc = pc; r.tgt = tgt;
    r.pred = pred; r.ifpc = ifpc; r.e_leap = e_leap; r.e_ifpt = e_ifpt;
    r.e_flush = e_flush; r.e_redir = e_redir; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic br, input logic jp, input logic [1:0] cond,
                       input logic [31:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pred, input logic [31:0] ifpc);
    ex_valid = v; ex_branch = br; ex_jump = jp; ex_cond = cond; ex_operand = op;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pred; if_pc = ifpc;
  endtask

  task automatic bubble(input logic [31:0] ifpc);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, ifpc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bubble(32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Table: state carries from one row to the next, starting from reset.
    tbl[0]  = mk(0,0,0,2'b00,32'h0,       32'h0,       32'h0,  0,32'h40,       0,0,0,32'h0,  2'd0);
    // eqz taken, predicted not-taken; lookup of the trained index reads the old value
    tbl[1]  = mk(1,1,0,2'b00,32'h0,       32'h100,     32'h200,0,32'h100,      1,0,1,32'h200,2'd1);
    tbl[2]  = mk(0,0,0,2'b00,32'h0,       32'h0,       32'h0,  0,32'h100,      0,1,0,32'h0,  2'd1);
    tbl[3]  = mk(1,1,0,2'b10,32'h80000000,32'h100,     32'h300,1,32'h100,      1,1,0,32'h0,  2'd1);
    tbl[4]  = mk(1,1,0,2'b10,32'h80000000,32'h100,     32'h300,1,32'h100,      1,1,0,32'h0,  2'd1);
    // saturated at 11 (a wrap to 00 would read 0 here); gez not taken -> fall through
    tbl[5]  = mk(1,1,0,2'b11,32'h80000000,32'h100,     32'h300,1,32'h100,      0,1,1,32'h104,2'd2);
    tbl[6]  = mk(0,0,0,2'b00,32'h0,       32'h0,       32'h0,  0,32'h100,      0,1,0,32'h0,  2'd2);
    tbl[7]  = mk(1,0,1,2'b00,32'h5,       32'hFFFFFFFC,32'h80, 0,32'hFFFFFFFC, 1,0,1,32'h80, 2'd3);
    tbl[8]  = mk(0,0,0,2'b00,32'h0,       32'h0,       32'h0,  0,32'hFFFFFFFC, 0,0,0,32'h0,  2'd3);
    // nez not taken, predicted taken: redirect wraps to 0, stat counter holds at 3
    tbl[9]  = mk(1,1,0,2'b01,32'h0,       32'hFFFFFFFC,32'h80, 1,32'hFFFFFFFC, 0,0,1,32'h0,  2'd3);
    tbl[10] = mk(0,0,0,2'b00,32'h0,       32'h0,       32'h0,  0,32'hFFFFFFFC, 0,0,0,32'h0,  2'd3);
    tbl[11] = mk(1,0,0,2'b00,32'h0,       32'h20,      32'h40, 1,32'h20,       0,0,0,32'h0,  2'd3);
    // branch+jump together behaves as a jump: taken, no training
    tbl[12] = mk(1,1,1,2'b00,32'h1,       32'h24,      32'h400,1,32'h24,       1,0,0,32'h0,  2'd3);
    tbl[13] = mk(0,0,0,2'b00,32'h0,       32'h0,       32'h0,  0,32'h24,       0,0,0,32'h0,  2'd3);
    tbl[14] = mk(0,1,0,2'b00,32'h0,       32'h24,      32'h500,0,32'h24,       0,0,0,32'h0,  2'd3);
    tbl[15] = mk(0,0,0,2'b00,32'h0,       32'h0,       32'h0,  0,32'h24,       0,0,0,32'h0,  2'd3);

    reset = 1'b1;
    bubble(32'h40);
    #2;
    chk("rst_if_pred", 64'(if_pred_taken), 64'd0);
    chk("rst_flush",   64'(flush),         64'd0);
    chk("rst_cnt",     64'(mispred_cnt),   64'd0);
    chk("rst_redir",   64'(redirect_pc),   64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].br, tbl[i].jp, tbl[i].cond, tbl[i].op, tbl[i].pc, tbl[i].tgt,
            tbl[i].pred, tbl[i].ifpc);
      #2;
      chk($sformatf("v%0d_leap", i),    64'(leap),          64'(tbl[i].e_leap));
      chk($sformatf("v%0d_if_pred", i), 64'(if_pred_taken), 64'(tbl[i].e_ifpt));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_flush", i), 64'(flush),       64'(tbl[i].e_flush));
      if (tbl[i].e_flush)
        chk($sformatf("v%0d_redir", i), 64'(redirect_pc), 64'(tbl[i].e_redir));
      chk($sformatf("v%0d_cnt", i),   64'(mispred_cnt), 64'(tbl[i].e_cnt));
    end

    // Wrong-path kill: a mispredicting branch right behind a mispredict is ignored.
    do_reset();
    @(negedge clk);
    drive(1, 1, 0, 2'b00, 32'h0, 32'h104, 32'h500, 0, 32'h108);
    @(posedge clk); #1;
    chk("kill_flush1", 64'(flush),       64'd1);
    chk("kill_redir1", 64'(redirect_pc), 64'h500);
    chk("kill_cnt1",   64'(mispred_cnt), 64'd1);
    @(negedge clk);
    drive(1, 1, 0, 2'b00, 32'h0, 32'h108, 32'h600, 0, 32'h108);
    #2;
    chk("kill_leap", 64'(leap), 64'd0);
    @(posedge clk); #1;
    chk("kill_flush2", 64'(flush),       64'd0);
    chk("kill_cnt2",   64'(mispred_cnt), 64'd1);
    @(negedge clk);
    bubble(32'h108);
    #2;
    chk("kill_no_train", 64'(if_pred_taken), 64'd0);
    if_pc = 32'h104;
    #1;
    chk("kill_first_trained", 64'(if_pred_taken), 64'd1);

    // Reset while flush is high: everything clears without waiting for a clock.
    @(negedge clk);
    drive(1, 1, 0, 2'b00, 32'h0, 32'h10C, 32'h700, 0, 32'h10C);
    @(posedge clk); #1;
    chk("rstf_flush_pre", 64'(flush), 64'd1);
    bubble(32'h104);
    #1;
    chk("rstf_trained_pre", 64'(if_pred_taken), 64'd1);
    reset = 1'b1;
    #1;
    chk("rstf_flush",   64'(flush),         64'd0);
    chk("rstf_redir",   64'(redirect_pc),   64'd0);
    chk("rstf_cnt",     64'(mispred_cnt),   64'd0);
    chk("rstf_if_pred", 64'(if_pred_taken), 64'd0);
    if_pc = 32'h10C;
    #1;
    chk("rstf_if_pred2", 64'(if_pred_taken), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_flush", 64'(flush), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
